// File: rtl/tone_decoder.sv
// Detects a game tone on an asynchronous square wave by counting its rising edges over 100 ms gate windows.
// The input must produce the same valid class in two consecutive windows before the tone is locked.
module tone_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  input  logic        sound_in,
  output logic [1:0]  tone,
  output logic        tone_valid,
  output logic        tone_event,
  output logic [11:0] freq_est
);

  typedef enum logic [1:0] {IDLE, CANDIDATE, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        prev_q;
  logic        rise;
  logic [15:0] tpm_eff;
  logic [15:0] tick_q;
  logic [6:0]  ms_q;
  logic        tick_last;
  logic        win_close;
  logic [7:0]  edge_cnt_q;
  logic [1:0]  cls;
  logic        cls_ok;
  logic [1:0]  cls_q, next_cls;
  state_t      state_q, next_state;

  assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign tpm_eff = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  // A comparison rather than an equality lets a lowered ticks_per_milli wrap on the next cycle.
  assign tick_last = (tick_q >= tpm_eff - 16'd1);
  assign win_close = tick_last && (ms_q == 7'd99);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      tick_q     <= 16'd0;
      ms_q       <= 7'd0;
      edge_cnt_q <= 8'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sound_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick_q <= tick_last ? 16'd0 : tick_q + 16'd1;
      if (tick_last) ms_q <= (ms_q == 7'd99) ? 7'd0 : ms_q + 7'd1;
      // An edge on the closing cycle belongs to the next window.
      if (win_close)
        edge_cnt_q <= rise ? 8'd1 : 8'd0;
      else if (rise && edge_cnt_q != 8'd255)
        edge_cnt_q <= edge_cnt_q + 8'd1;
    end
  end

  always_comb begin
    cls    = 2'd0;
    cls_ok = 1'b1;
    if (edge_cnt_q >= 8'd17 && edge_cnt_q <= 8'd22)      cls = 2'd0;
    else if (edge_cnt_q >= 8'd24 && edge_cnt_q <= 8'd29) cls = 2'd1;
    else if (edge_cnt_q >= 8'd31 && edge_cnt_q <= 8'd36) cls = 2'd2;
    else if (edge_cnt_q >= 8'd74 && edge_cnt_q <= 8'd84) cls = 2'd3;
    else                                                 cls_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q   <= 2'd0;
    end else begin
      state_q <= next_state;
      cls_q   <= next_cls;
    end
  end

  always_comb begin
    next_state = state_q;
    next_cls   = cls_q;
    if (win_close) begin
      case (state_q)
        IDLE: begin
          if (cls_ok) begin
            next_state = CANDIDATE;
            next_cls   = cls;
          end
        end
        CANDIDATE: begin
          if (!cls_ok)            next_state = IDLE;
          else if (cls == cls_q)  next_state = LOCKED;
          else                    next_cls   = cls;
        end
        LOCKED: begin
          if (!cls_ok) next_state = IDLE;
          else if (cls != cls_q) begin
            next_state = CANDIDATE;
            next_cls   = cls;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tone       <= 2'd0;
      tone_valid <= 1'b0;
      tone_event <= 1'b0;
      freq_est   <= 12'd0;
    end else if (win_close) begin
      tone_valid <= (next_state == LOCKED);
      tone_event <= (next_state == LOCKED) && (state_q != LOCKED);
      if (next_state == LOCKED) tone <= next_cls;
      freq_est   <= 12'(edge_cnt_q) * 12'd10;
    end else begin
      tone_event <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: square waves of known period, windows of 5000 cycles at 50 ticks/ms.
module tb_tone_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ticks_per_milli = 16'd50;
  logic        sound_in = 1'b0;
  logic [1:0]  tone;
  logic        tone_valid;
  logic        tone_event;
  logic [11:0] freq_est;

  int checks = 0;
  int errors = 0;
  int period = 0;
  int phase = 0;
  int ev_cnt = 0;

  localparam int WIN = 5000;

  tone_decoder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli), .sound_in(sound_in),
    .tone(tone), .tone_valid(tone_valid), .tone_event(tone_event), .freq_est(freq_est)
  );

  always #5 clk = ~clk;

  // Square-wave source: high for period/2 cycles, low for the rest; period 0 means silence.
  always @(negedge clk) begin
    if (period == 0) begin
      sound_in = 1'b0;
      phase = 0;
    end else begin
      sound_in = (phase < period / 2);
      phase = (phase + 1 >= period) ? 0 : phase + 1;
    end
  end

  always @(negedge clk) if (tone_event === 1'b1) ev_cnt++;

  // Reset is released at a negedge, so window n ends n*WIN posedges later.
  task automatic do_reset(input int new_period);
    @(negedge clk);
    rst = 1'b1;
    period = new_period;
    phase = 0;
    repeat (3) @(negedge clk);
    ev_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic wait_win(input int n, input int win_len);
    repeat (n * win_len) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tone, tone_valid, tone_event, freq_est} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got tone=%0d valid=%0b event=%0b freq=%0d, want all 0",
               tone, tone_valid, tone_event, freq_est);
    end
  endtask

  task automatic test_262;
    do_reset(191);
    wait_win(1, WIN);
    checks++;
    if (tone_valid !== 1'b0) begin
      errors++; $display("FAIL t262_w1_valid: got %0b want 0", tone_valid);
    end
    wait_win(1, WIN);
    checks++;
    if (tone_valid !== 1'b1 || tone !== 2'd1) begin
      errors++; $display("FAIL t262_lock: got valid=%0b tone=%0d want valid=1 tone=1", tone_valid, tone);
    end
    checks++;
    if (tone_event !== 1'b1) begin
      errors++; $display("FAIL t262_event_now: got %0b want 1", tone_event);
    end
    checks++;
    if (freq_est !== 12'd260 && freq_est !== 12'd270) begin
      errors++; $display("FAIL t262_freq: got %0d want 260 or 270", freq_est);
    end
    @(posedge clk); #1;
    checks++;
    if (tone_event !== 1'b0) begin
      errors++; $display("FAIL t262_event_width: got %0b want 0", tone_event);
    end
    repeat (10) @(posedge clk); #1;
    checks++;
    if (ev_cnt != 1) begin
      errors++; $display("FAIL t262_event_count: got %0d want 1", ev_cnt);
    end
  endtask

  task automatic test_silent;
    do_reset(0);
    for (int w = 1; w <= 2; w++) begin
      wait_win(1, WIN);
      checks++;
      if (freq_est !== 12'd0 || tone_valid !== 1'b0) begin
        errors++; $display("FAIL silent_w%0d: got freq=%0d valid=%0b want 0/0", w, freq_est, tone_valid);
      end
    end
    checks++;
    if (ev_cnt != 0) begin
      errors++; $display("FAIL silent_events: got %0d want 0", ev_cnt);
    end
  endtask

  task automatic test_switch;
    do_reset(255);
    wait_win(2, WIN);
    checks++;
    if (tone_valid !== 1'b1 || tone !== 2'd0) begin
      errors++; $display("FAIL sw_lock196: got valid=%0b tone=%0d want 1/0", tone_valid, tone);
    end
    period = 64;
    phase = 0;
    wait_win(1, WIN);
    checks++;
    if (tone_valid !== 1'b0 || tone !== 2'd0) begin
      errors++; $display("FAIL sw_drop: got valid=%0b tone=%0d want 0/0", tone_valid, tone);
    end
    wait_win(1, WIN);
    checks++;
    if (tone_valid !== 1'b1 || tone !== 2'd3) begin
      errors++; $display("FAIL sw_relock784: got valid=%0b tone=%0d want 1/3", tone_valid, tone);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (ev_cnt != 2) begin
      errors++; $display("FAIL sw_events: got %0d want 2", ev_cnt);
    end
  endtask

  task automatic test_500;
    do_reset(100);
    wait_win(2, WIN);
    checks++;
    if (freq_est !== 12'd500 || tone_valid !== 1'b0) begin
      errors++; $display("FAIL f500: got freq=%0d valid=%0b want 500/0", freq_est, tone_valid);
    end
    checks++;
    if (ev_cnt != 0) begin
      errors++; $display("FAIL f500_events: got %0d want 0", ev_cnt);
    end
  endtask

  task automatic test_saturate;
    do_reset(2);
    wait_win(1, WIN);
    checks++;
    if (freq_est !== 12'd2550 || tone_valid !== 1'b0) begin
      errors++; $display("FAIL saturate: got freq=%0d valid=%0b want 2550/0", freq_est, tone_valid);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(152);
    wait_win(2, WIN);
    checks++;
    if (tone_valid !== 1'b1 || tone !== 2'd2) begin
      errors++; $display("FAIL mr_lock330: got valid=%0b tone=%0d want 1/2", tone_valid, tone);
    end
    repeat (2000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tone, tone_valid, tone_event, freq_est} !== 16'd0) begin
      errors++;
      $display("FAIL mr_cleared: got tone=%0d valid=%0b event=%0b freq=%0d want all 0",
               tone, tone_valid, tone_event, freq_est);
    end
    wait_win(1, WIN);
    checks++;
    if (tone_valid !== 1'b0) begin
      errors++; $display("FAIL mr_w1_valid: got %0b want 0", tone_valid);
    end
    wait_win(1, WIN);
    checks++;
    if (tone_valid !== 1'b1 || tone !== 2'd2 || tone_event !== 1'b1) begin
      errors++; $display("FAIL mr_relock: got valid=%0b tone=%0d event=%0b want 1/2/1", tone_valid, tone, tone_event);
    end
  endtask

  // ticks_per_milli=0 acts as 1: 100-cycle windows, 50 edges each from a period-2 wave.
  task automatic test_zero_tpm;
    ticks_per_milli = 16'd0;
    do_reset(2);
    wait_win(2, 100);
    checks++;
    if (freq_est !== 12'd500) begin
      errors++; $display("FAIL zero_tpm: got freq=%0d want 500", freq_est);
    end
    ticks_per_milli = 16'd50;
  endtask

  initial begin
    test_reset;
    test_262;
    test_silent;
    test_switch;
    test_500;
    test_saturate;
    test_mid_reset;
    test_zero_tpm;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
